memory_read_sequencer: RTL and testbench

Read-side companion to the memory_system write demux. It reads back the four 8-bit storage banks (A–D) through a registered 4:1 select and streams a burst of bytes out over a valid/ready handshake. A burst starts at any bank, is 1–4 beats long and wraps from D back to A. The block sits between the bank registers and the display/consumer logic.

---
 rtl/memory_read_sequencer.sv | 130 +++++++++++++
 tb/tb_memory_read_sequencer.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_read_sequencer.sv
// memory_read_sequencer
// Reads back the four storage banks (A-D) through a registered 4:1 select and
// streams a 1-4 beat burst over a valid/ready handshake. Bank selection starts
// at start_sel and wraps from D back to A.
//
// Optional build macro: READ_PARITY_EN adds out_parity, the XOR reduction of
// out_data, captured alongside it on the fetch edge.
module memory_read_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       start_sel,
    input  logic [2:0]       len,
    input  logic [WIDTH-1:0] bank_a,
    input  logic [WIDTH-1:0] bank_b,
    input  logic [WIDTH-1:0] bank_c,
    input  logic [WIDTH-1:0] bank_d,
    output logic [1:0]       rd_sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
`ifdef READ_PARITY_EN
    output logic             out_parity,
`endif
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state;
    logic [2:0]       rem;
    logic [2:0]       len_norm;
    logic [WIDTH-1:0] bank_mux;

    // Normalise the requested length: 1..4 are literal, 0 and 5..7 become 4.
    // NOTE: every always_comb output gets a value on every path (here via the
    // default arm) so no latch is inferred.
    always_comb begin
        len_norm = 3'd4;
        case (len)
            3'd1, 3'd2, 3'd3, 3'd4: len_norm = len;
            default:                len_norm = 3'd4;
        endcase
    end

    // Select the bank addressed by the latched read pointer.
    always_comb begin
        bank_mux = bank_a;
        case (rd_sel)
            2'd0: bank_mux = bank_a;
            2'd1: bank_mux = bank_b;
            2'd2: bank_mux = bank_c;
            2'd3: bank_mux = bank_d;
            default: bank_mux = bank_a;
        endcase
    end

    // Burst sequencer: latch the request, fetch one bank per beat, hold each
    // beat until the consumer accepts it, then advance or finish.
    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from the values present before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rd_sel    <= 2'd0;
            rem       <= 3'd0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rd_sel <= start_sel;
                        rem    <= len_norm;
                        busy   <= 1'b1;
                        state  <= FETCH;
                    end
                end
                FETCH: begin
                    out_data  <= bank_mux;
                    out_valid <= 1'b1;
                    out_last  <= (rem == 3'd1);
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            out_last <= 1'b0;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            rd_sel <= rd_sel + 2'd1;
                            rem    <= rem - 3'd1;
                            state  <= FETCH;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef READ_PARITY_EN
    // Parity travels with the beat: captured on the fetch edge, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_parity <= 1'b0;
        end else if (state == FETCH) begin
            out_parity <= ^bank_mux;
        end
    end
`endif

endmodule

// File: tb/tb_memory_read_sequencer.sv
// Directed testbench for memory_read_sequencer. Banks hold A=0x11, B=0x22,
// C=0x33, D=0x44 unless a scenario changes them. Inputs are driven and
// outputs sampled 1 time unit after each rising edge.
module tb_memory_read_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] start_sel;
    logic [2:0] len;
    logic [7:0] bank_a, bank_b, bank_c, bank_d;
    logic [1:0] rd_sel;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
`ifdef READ_PARITY_EN
    logic       out_parity;
`endif
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    // Capture results of one burst
    logic [7:0] cap_data [8];
    logic       cap_last [8];
    logic [1:0] cap_sel  [8];
    int         nbeats;
    int         ndone;
    int         nbusy;
    int         first_valid_cyc;
    bit         timed_out;

    memory_read_sequencer #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .start_sel (start_sel),
        .len       (len),
        .bank_a    (bank_a),
        .bank_b    (bank_b),
        .bank_c    (bank_c),
        .bank_d    (bank_d),
        .rd_sel    (rd_sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
`ifdef READ_PARITY_EN
        .out_parity(out_parity),
`endif
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one burst whose start has already been driven. Stalls the first
    // 'stall' presented beats, optionally pulses start at cycle glitch_cyc,
    // and returns right after the sample where done is seen.
    task automatic run_capture(input int budget, input int stall, input int glitch_cyc);
        int stalled;
        int cyc;
        stalled = 0;
        cyc = 0;
        nbeats = 0;
        ndone = 0;
        nbusy = 0;
        timed_out = 1'b0;
        first_valid_cyc = -1;
        for (int i = 0; i < 8; i++) begin
            cap_data[i] = 'x;
            cap_last[i] = 1'bx;
            cap_sel[i]  = 2'bxx;
        end
        tick();
        start = 1'b0;
        forever begin
            if (busy === 1'b1) nbusy++;
            if (done === 1'b1) begin
                ndone++;
                break;
            end
            if (cyc >= budget) begin
                timed_out = 1'b1;
                break;
            end
            start = (cyc == glitch_cyc);
            if (cyc == glitch_cyc) begin
                start_sel = 2'd0;
                len = 3'd4;
            end
            out_ready = 1'b1;
            if (out_valid === 1'b1) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (stalled < stall) begin
                    out_ready = 1'b0;
                    stalled++;
                end else if (nbeats < 8) begin
                    cap_data[nbeats] = out_data;
                    cap_last[nbeats] = out_last;
                    cap_sel[nbeats]  = rd_sel;
                    nbeats++;
                end
            end
            tick();
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0; start_sel = 2'd0; len = 3'd0; out_ready = 1'b0;
        bank_a = 8'h11; bank_b = 8'h22; bank_c = 8'h33; bank_d = 8'h44;
        #1;
        checks++;
        if ({out_data, out_valid, out_last, rd_sel, busy, done} !== 14'd0) begin
            failures++;
            $display("FAIL reset_outputs got data=%h valid=%b last=%b sel=%0d busy=%b done=%b exp all 0",
                     out_data, out_valid, out_last, rd_sel, busy, done);
        end
`ifdef READ_PARITY_EN
        checks++;
        if (out_parity !== 1'b0) begin
            failures++;
            $display("FAIL reset_parity got=%b exp=0", out_parity);
        end
`endif
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_burst();
        start = 1'b1; start_sel = 2'd0; len = 3'd4; out_ready = 1'b0;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h11) begin
            failures++;
            $display("FAIL midrst_pre valid=%b data=%h exp valid=1 data=11", out_valid, out_data);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_data, out_valid, out_last, rd_sel, busy, done} !== 14'd0) begin
            failures++;
            $display("FAIL midrst_async got data=%h valid=%b last=%b sel=%0d busy=%b done=%b exp all 0",
                     out_data, out_valid, out_last, rd_sel, busy, done);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midrst_nodone done=%b busy=%b exp 0 0", done, busy);
        end
        rst_n = 1'b1;
        tick();
        start = 1'b1; start_sel = 2'd0; len = 3'd1;
        run_capture(20, 0, -1);
        checks++;
        if (timed_out || nbeats != 1 || cap_data[0] !== 8'h11 || ndone != 1) begin
            failures++;
            $display("FAIL midrst_restart timeout=%0d beats=%0d data=%h done=%0d exp 0 1 11 1",
                     timed_out, nbeats, cap_data[0], ndone);
        end
        tick();
    endtask

    task automatic test_simple_burst();
        start = 1'b1; start_sel = 2'd1; len = 3'd2; out_ready = 1'b1;
        run_capture(30, 0, -1);
        checks++;
        if (timed_out || nbeats != 2) begin
            failures++;
            $display("FAIL simple_beats timeout=%0d beats=%0d exp 0 2", timed_out, nbeats);
        end
        checks++;
        if (cap_data[0] !== 8'h22 || cap_data[1] !== 8'h33) begin
            failures++;
            $display("FAIL simple_data got %h %h exp 22 33", cap_data[0], cap_data[1]);
        end
        checks++;
        if (cap_last[0] !== 1'b0 || cap_last[1] !== 1'b1) begin
            failures++;
            $display("FAIL simple_last got %b %b exp 0 1", cap_last[0], cap_last[1]);
        end
        checks++;
        if (nbusy != 4) begin
            failures++;
            $display("FAIL simple_busy_cycles got=%0d exp=4", nbusy);
        end
        checks++;
        if (first_valid_cyc != 1) begin
            failures++;
            $display("FAIL simple_latency got=%0d exp=1", first_valid_cyc);
        end
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL simple_end busy=%b valid=%b exp 0 0", busy, out_valid);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL simple_done_pulse got=%b exp=0 (one cycle only)", done);
        end
    endtask

    task automatic test_wrap_len0();
        logic [7:0] exp_d [4];
        logic [1:0] exp_s [4];
        exp_d[0] = 8'h44; exp_d[1] = 8'h11; exp_d[2] = 8'h22; exp_d[3] = 8'h33;
        exp_s[0] = 2'd3;  exp_s[1] = 2'd0;  exp_s[2] = 2'd1;  exp_s[3] = 2'd2;
        start = 1'b1; start_sel = 2'd3; len = 3'd0;
        run_capture(40, 0, -1);
        checks++;
        if (timed_out || nbeats != 4 || ndone != 1) begin
            failures++;
            $display("FAIL wrap_beats timeout=%0d beats=%0d done=%0d exp 0 4 1", timed_out, nbeats, ndone);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap_data[i] !== exp_d[i] || cap_sel[i] !== exp_s[i] || cap_last[i] !== (i == 3)) begin
                failures++;
                $display("FAIL wrap_beat%0d got data=%h sel=%0d last=%b exp data=%h sel=%0d last=%0d",
                         i, cap_data[i], cap_sel[i], cap_last[i], exp_d[i], exp_s[i], (i == 3));
            end
        end
        tick();
    endtask

    task automatic test_backpressure();
        start = 1'b1; start_sel = 2'd2; len = 3'd1; out_ready = 1'b0;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h33 || out_last !== 1'b1 || rd_sel !== 2'd2 || done !== 1'b0) begin
                failures++;
                $display("FAIL stall%0d got valid=%b data=%h last=%b sel=%0d done=%b exp 1 33 1 2 0",
                         i, out_valid, out_data, out_last, rd_sel, done);
            end
            if (i == 1) bank_c = 8'h99;
            tick();
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL stall_release got done=%b valid=%b busy=%b exp 1 0 0", done, out_valid, busy);
        end
        bank_c = 8'h33;
        tick();
    endtask

    task automatic test_ignored_start();
        start = 1'b1; start_sel = 2'd1; len = 3'd3;
        run_capture(40, 0, 2);
        checks++;
        if (timed_out || nbeats != 3 || ndone != 1) begin
            failures++;
            $display("FAIL ignore_beats timeout=%0d beats=%0d done=%0d exp 0 3 1", timed_out, nbeats, ndone);
        end
        checks++;
        if (cap_data[0] !== 8'h22 || cap_data[1] !== 8'h33 || cap_data[2] !== 8'h44) begin
            failures++;
            $display("FAIL ignore_data got %h %h %h exp 22 33 44", cap_data[0], cap_data[1], cap_data[2]);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL ignore_extra%0d got valid=%b busy=%b exp 0 0", i, out_valid, busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        start = 1'b1; start_sel = 2'd2; len = 3'd1;
        run_capture(20, 0, -1);
        checks++;
        if (timed_out || nbeats != 1 || cap_data[0] !== 8'h33) begin
            failures++;
            $display("FAIL b2b_first timeout=%0d beats=%0d data=%h exp 0 1 33", timed_out, nbeats, cap_data[0]);
        end
        // start during the done cycle, with len=7 clamped to 4
        start = 1'b1; start_sel = 2'd0; len = 3'd7;
        run_capture(40, 0, -1);
        checks++;
        if (timed_out || nbeats != 4 || first_valid_cyc != 1) begin
            failures++;
            $display("FAIL b2b_second timeout=%0d beats=%0d first_valid=%0d exp 0 4 1",
                     timed_out, nbeats, first_valid_cyc);
        end
        checks++;
        if (cap_data[0] !== 8'h11 || cap_data[3] !== 8'h44 || cap_last[3] !== 1'b1 || cap_last[2] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_data got %h..%h last2=%b last3=%b exp 11..44 0 1",
                     cap_data[0], cap_data[3], cap_last[2], cap_last[3]);
        end
        tick();
    endtask

`ifdef READ_PARITY_EN
    task automatic test_parity();
        bank_a = 8'h07;
        start = 1'b1; start_sel = 2'd0; len = 3'd1; out_ready = 1'b0;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (out_data !== 8'h07 || out_parity !== 1'b1) begin
            failures++;
            $display("FAIL parity_07 got data=%h par=%b exp 07 1", out_data, out_parity);
        end
        out_ready = 1'b1;
        tick();
        tick();
        bank_a = 8'h11;
        start = 1'b1; out_ready = 1'b0;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (out_data !== 8'h11 || out_parity !== 1'b0) begin
            failures++;
            $display("FAIL parity_11 got data=%h par=%b exp 11 0", out_data, out_parity);
        end
        out_ready = 1'b1;
        tick();
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_reset_mid_burst();
        test_simple_burst();
        test_wrap_len0();
        test_backpressure();
        test_ignored_start();
        test_back_to_back();
`ifdef READ_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
